// File: rtl/sram_100_qsys_cpu_oci_dct_packer_pkg.sv
// Shared sizing and state encoding for the OCI branch-code (DCT) packer.
package sram_100_qsys_cpu_oci_dct_packer_pkg;

  localparam int DCT_MAX_ENTRIES = 15;
  localparam int DCT_CODE_W      = 2;
  localparam int DCT_BUF_W       = DCT_MAX_ENTRIES * DCT_CODE_W;  // 30
  localparam int DCT_CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } dct_state_e;

endpackage

// File: rtl/sram_100_qsys_cpu_oci_dct_accum.sv
// Shift accumulator for branch codes: newest code enters at the LSBs, count saturates at MAX_ENTRIES.
module sram_100_qsys_cpu_oci_dct_accum
  import sram_100_qsys_cpu_oci_dct_packer_pkg::*;
#(
  parameter int MAX_ENTRIES = DCT_MAX_ENTRIES,
  parameter int CODE_W      = DCT_CODE_W,
  localparam int BUF_W      = MAX_ENTRIES * CODE_W,
  localparam int CNT_W      = $clog2(MAX_ENTRIES + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_push,
  input  logic [CODE_W-1:0] i_code,
  input  logic              i_xfer,
  output logic [BUF_W-1:0]  o_buf,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_full,
  output logic [BUF_W-1:0]  o_nxt_buf,
  output logic [CNT_W-1:0]  o_nxt_cnt
);

  logic [BUF_W-1:0] r_buf;
  logic [CNT_W-1:0] r_cnt;
  logic             w_full;
  logic             w_push_ok;
  logic [BUF_W-1:0] w_nxt_buf;
  logic [CNT_W-1:0] w_nxt_cnt;

  assign w_full    = (r_cnt == CNT_W'(MAX_ENTRIES));
  assign w_push_ok = i_push & ~w_full;
  assign w_nxt_buf = w_push_ok ? {r_buf[BUF_W-CODE_W-1:0], i_code} : r_buf;
  assign w_nxt_cnt = r_cnt + CNT_W'(w_push_ok);

  // When a full accumulator drains, a code arriving that cycle starts the next packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (i_xfer) begin
      if (w_full && i_push) begin
        r_buf <= BUF_W'(i_code);
        r_cnt <= CNT_W'(1);
      end else begin
        r_buf <= '0;
        r_cnt <= '0;
      end
    end else if (w_push_ok) begin
      r_buf <= w_nxt_buf;
      r_cnt <= w_nxt_cnt;
    end
  end

  assign o_buf     = r_buf;
  assign o_cnt     = r_cnt;
  assign o_full    = w_full;
  assign o_nxt_buf = w_nxt_buf;
  assign o_nxt_cnt = w_nxt_cnt;

endmodule

// File: rtl/sram_100_qsys_cpu_oci_dct_packer.sv
// Packs 2-bit branch outcome codes into 15-entry packets with a ready/valid output register and end-of-test drain.
module sram_100_qsys_cpu_oci_dct_packer
  import sram_100_qsys_cpu_oci_dct_packer_pkg::*;
#(
  parameter int MAX_ENTRIES = DCT_MAX_ENTRIES,
  parameter int CODE_W      = DCT_CODE_W,
  localparam int BUF_W      = MAX_ENTRIES * CODE_W,
  localparam int CNT_W      = $clog2(MAX_ENTRIES + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              br_valid,
  input  logic [CODE_W-1:0] br_code,
  input  logic              flush_req,
  input  logic              test_ending,
  input  logic              dct_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              dct_valid,
  output logic              overflow,
  output logic              test_has_ended
);

  dct_state_e       r_state, w_state_nxt;
  logic [BUF_W-1:0] r_out_buf;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_out_vld;
  logic             r_flush_pend;
  logic             r_overflow;
  logic             r_ended;

  logic [BUF_W-1:0] w_acc_buf, w_nxt_buf;
  logic [CNT_W-1:0] w_acc_cnt, w_nxt_cnt;
  logic             w_acc_full;
  logic             w_run, w_drain;
  logic             w_push, w_out_free, w_flush, w_want, w_xfer, w_drop;

  assign w_run      = (r_state == ST_RUN);
  assign w_drain    = (r_state == ST_DRAIN);
  assign w_push     = w_run & br_valid;
  assign w_out_free = ~r_out_vld | dct_ready;
  assign w_flush    = w_drain | (w_run & (flush_req | r_flush_pend));
  // A full accumulator reports nxt_cnt == MAX_ENTRIES, so it always wants to drain.
  assign w_want     = (w_nxt_cnt == CNT_W'(MAX_ENTRIES)) | (w_flush & (w_nxt_cnt != '0));
  assign w_xfer     = w_want & w_out_free;
  assign w_drop     = w_push & w_acc_full & ~w_xfer;

  sram_100_qsys_cpu_oci_dct_accum #(
    .MAX_ENTRIES (MAX_ENTRIES),
    .CODE_W      (CODE_W)
  ) u_accum (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_push    (w_push),
    .i_code    (br_code),
    .i_xfer    (w_xfer),
    .o_buf     (w_acc_buf),
    .o_cnt     (w_acc_cnt),
    .o_full    (w_acc_full),
    .o_nxt_buf (w_nxt_buf),
    .o_nxt_cnt (w_nxt_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_RUN;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (test_ending) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if ((w_acc_cnt == '0) && w_out_free) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_buf    <= '0;
      r_out_cnt    <= '0;
      r_out_vld    <= 1'b0;
      r_flush_pend <= 1'b0;
      r_overflow   <= 1'b0;
      r_ended      <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_out_buf <= w_nxt_buf;
        r_out_cnt <= w_nxt_cnt;
        r_out_vld <= 1'b1;
      end else if (dct_ready) begin
        r_out_vld <= 1'b0;
      end
      // Flush blocked by a busy output is replayed once the output frees up.
      if (w_xfer || !w_run)
        r_flush_pend <= 1'b0;
      else if (flush_req && (w_nxt_cnt != '0))
        r_flush_pend <= 1'b1;
      r_overflow <= w_drop;
      r_ended    <= (w_state_nxt == ST_DONE);
    end
  end

  assign dct_buffer     = r_out_buf;
  assign dct_count      = r_out_cnt;
  assign dct_valid      = r_out_vld;
  assign overflow       = r_overflow;
  assign test_has_ended = r_ended;

endmodule
